// File: rtl/kvs_axi_read_master.sv
// AXI4 read master: issues AR bursts over a contiguous byte range and streams the
// returned R beats straight onto a 512-bit AXI4-Stream with a bounded outstanding count.
module kvs_axi_read_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
  parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
  parameter int unsigned C_BURST_LEN        = 64,
  parameter int unsigned C_MAX_OUTSTANDING  = 16
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic                          ctrl_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
  output logic                          ctrl_done,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata
);

  localparam int unsigned NW = C_XFER_SIZE_WIDTH - 5;
  localparam int unsigned CW = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [NW-1:0] BURST_BEATS = NW'(C_BURST_LEN);
  localparam logic [CW-1:0] MAX_OUT = CW'(C_MAX_OUTSTANDING);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_STRIDE = C_M_AXI_ADDR_WIDTH'(C_BURST_LEN * 64);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] OFS_MASK = BURST_STRIDE - C_M_AXI_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [NW-1:0]          n_beats;
  logic [NW-1:0]          ar_rem;
  logic [NW-1:0]          beat_cnt;
  logic [CW-1:0]          outstanding;

  logic [C_XFER_SIZE_WIDTH:0]    size_round;
  logic [NW-1:0]                 n_start;
  logic [C_M_AXI_ADDR_WIDTH-1:0] base_aligned;
  logic                          run;
  logic                          ar_hs;
  logic                          t_hs;
  logic                          r_last_hs;
  logic                          ar_slot_free;
  logic [NW-1:0]                 rem_next;
  logic [CW-1:0]                 cnt_next;
  logic                          issue_next;

  function automatic logic [7:0] burst_arlen(input logic [NW-1:0] rem);
    if (rem >= BURST_BEATS) return 8'(C_BURST_LEN - 1);
    else                    return 8'(rem - NW'(1));
  endfunction

  assign size_round   = {1'b0, ctrl_xfer_size_in_bytes} + (C_XFER_SIZE_WIDTH + 1)'(63);
  assign n_start      = NW'(size_round >> 6);
  assign base_aligned = ctrl_addr_offset & ~OFS_MASK;

  assign run           = (state == RUN);
  assign m_axis_tvalid = m_axi_rvalid & run;
  assign m_axi_rready  = m_axis_tready & run;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = m_axis_tvalid & (beat_cnt == n_beats - NW'(1));

  assign t_hs         = m_axis_tvalid & m_axis_tready;
  assign r_last_hs    = t_hs & m_axi_rlast;
  assign ar_hs        = m_axi_arvalid & m_axi_arready;
  assign ar_slot_free = ~m_axi_arvalid | m_axi_arready;

  // Look-ahead of remaining beats and outstanding count so a new AR can follow
  // an accepted one in the very next cycle.
  always_comb begin
    rem_next = ar_rem;
    if (ar_hs) rem_next = ar_rem - (NW'(m_axi_arlen) + NW'(1));
    cnt_next = outstanding;
    if (ar_hs && !r_last_hs)      cnt_next = outstanding + CW'(1);
    else if (!ar_hs && r_last_hs) cnt_next = outstanding - CW'(1);
    issue_next = (rem_next != '0) && (cnt_next < MAX_OUT);
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state         <= IDLE;
      ctrl_done     <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      n_beats       <= '0;
      ar_rem        <= '0;
      beat_cnt      <= '0;
      outstanding   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ctrl_done <= 1'b0;
          if (ctrl_start) begin
            n_beats      <= n_start;
            ar_rem       <= n_start;
            beat_cnt     <= '0;
            outstanding  <= '0;
            m_axi_araddr <= base_aligned;
            m_axi_arlen  <= burst_arlen(n_start);
            if (n_start == '0) begin
              state <= DONE;
            end else begin
              state         <= RUN;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        RUN: begin
          outstanding <= cnt_next;
          ar_rem      <= rem_next;
          if (ar_hs) m_axi_araddr <= m_axi_araddr + BURST_STRIDE;
          if (ar_slot_free) begin
            m_axi_arvalid <= issue_next;
            if (issue_next) m_axi_arlen <= burst_arlen(rem_next);
          end
          if (t_hs) begin
            beat_cnt <= beat_cnt + NW'(1);
            if (m_axis_tlast) begin
              state         <= DONE;
              ctrl_done     <= 1'b1;
              m_axi_arvalid <= 1'b0;
            end
          end
        end
        DONE: begin
          // Entered with done already high from RUN; an empty transfer arrives
          // with done low and spends one extra cycle here to raise it.
          m_axi_arvalid <= 1'b0;
          if (ctrl_done) begin
            ctrl_done <= 1'b0;
            state     <= IDLE;
          end else begin
            ctrl_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kvs_axi_read_master.sv
// Directed bench for kvs_axi_read_master: a negedge-driven memory model answers ARs
// with address-derived data while each test task checks the recorded behaviour.
module tb_kvs_axi_read_master;

  logic         aclk = 1'b0;
  logic         areset_n = 1'b0;
  logic         ctrl_start = 1'b0;
  logic [63:0]  ctrl_addr_offset = '0;
  logic [31:0]  ctrl_xfer_size_in_bytes = '0;
  logic         ctrl_done;
  logic         m_axi_arvalid;
  logic         m_axi_arready = 1'b0;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic         m_axi_rvalid = 1'b0;
  logic         m_axi_rready;
  logic [511:0] m_axi_rdata = '0;
  logic         m_axi_rlast = 1'b0;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
  logic [511:0] m_axis_tdata;

  kvs_axi_read_master #(
    .C_M_AXI_ADDR_WIDTH(64), .C_M_AXI_DATA_WIDTH(512), .C_XFER_SIZE_WIDTH(32),
    .C_BURST_LEN(64), .C_MAX_OUTSTANDING(16)
  ) dut (
    .aclk(aclk), .areset_n(areset_n), .ctrl_start(ctrl_start),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .ctrl_done(ctrl_done),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t          ar_q[$];
  ar_t          ar_log[$];
  logic [511:0] beat_data[$];
  bit           beat_last[$];
  int unsigned  beat_cyc[$];
  int unsigned  done_cyc[$];
  int unsigned  cyc = 0;
  int unsigned  start_cyc = 0;
  int unsigned  arvalid_cycles = 0;
  int unsigned  rr_bad = 0;
  int unsigned  burst_beat = 0;
  int           r_release = -1;
  bit           ar_ready_cfg = 1'b1;
  bit           r_enable = 1'b1;
  bit           r_force = 1'b0;
  bit           tready_rand = 1'b0;
  bit           tready_cfg = 1'b1;
  bit           start_req = 1'b0;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [511:0] pat(input logic [63:0] a);
    return {16{a[37:6] ^ 32'h5A5A_0000}};
  endfunction

  function automatic int data_bad(input logic [63:0] base);
    int n = 0;
    for (int i = 0; i < beat_data.size(); i++)
      if (beat_data[i] !== pat(base + 64'(i) * 64)) n++;
    return n;
  endfunction

  function automatic int tlast_count();
    int n = 0;
    for (int i = 0; i < beat_last.size(); i++) if (beat_last[i]) n++;
    return n;
  endfunction

  function automatic int tlast_index();
    int idx = -1;
    for (int i = 0; i < beat_last.size(); i++) if (beat_last[i]) idx = i;
    return idx;
  endfunction

  // One clock of stimulus: drive at negedge, observe 1ns later (before the posedge).
  task automatic cycle();
    @(negedge aclk);
    ctrl_start = start_req;
    if (start_req) start_cyc = cyc;
    start_req = 1'b0;
    m_axi_arready = ar_ready_cfg;
    m_axis_tready = tready_rand ? 1'($urandom_range(0, 1)) : tready_cfg;
    if (r_force) begin
      m_axi_rvalid = 1'b1; m_axi_rdata = '0; m_axi_rlast = 1'b0;
    end else if (r_enable && ar_q.size() > 0 && r_release != 0) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = pat(ar_q[0].addr + 64'(burst_beat) * 64);
      m_axi_rlast  = (burst_beat == int'(ar_q[0].len));
    end else begin
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    end
    #1;
    if (m_axi_arvalid) arvalid_cycles++;
    if (m_axi_arvalid && m_axi_arready) begin
      ar_q.push_back('{addr: m_axi_araddr, len: m_axi_arlen});
      ar_log.push_back('{addr: m_axi_araddr, len: m_axi_arlen});
    end
    if (m_axis_tvalid && (m_axi_rready !== m_axis_tready)) rr_bad++;
    if (!r_force && m_axi_rvalid && m_axi_rready) begin
      if (m_axi_rlast) begin
        void'(ar_q.pop_front());
        burst_beat = 0;
        if (r_release > 0) r_release--;
      end else begin
        burst_beat++;
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      beat_data.push_back(m_axis_tdata);
      beat_last.push_back(m_axis_tlast);
      beat_cyc.push_back(cyc);
    end
    if (ctrl_done) done_cyc.push_back(cyc);
    cyc++;
  endtask

  task automatic reset_logs();
    ar_log.delete(); beat_data.delete(); beat_last.delete();
    beat_cyc.delete(); done_cyc.delete();
    arvalid_cycles = 0; rr_bad = 0;
  endtask

  task automatic apply_reset();
    areset_n = 1'b0;
    repeat (3) cycle();
    areset_n = 1'b1;
    ar_q.delete(); burst_beat = 0;
    cycle();
  endtask

  task automatic run_xfer(input logic [63:0] base, input logic [31:0] size,
                          input int budget, input int mid_start_at);
    reset_logs();
    ctrl_addr_offset = base;
    ctrl_xfer_size_in_bytes = size;
    start_req = 1'b1;
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) begin
      if (i == mid_start_at) begin
        start_req = 1'b1;
        ctrl_xfer_size_in_bytes = 32'd64;
      end
      cycle();
    end
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    r_force = 1'b1; tready_cfg = 1'b1;
    areset_n = 1'b0;
    repeat (2) cycle();
    checks++;
    if ({m_axi_arvalid, ctrl_done, m_axi_rready, m_axis_tvalid, m_axis_tlast} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
               {m_axi_arvalid, ctrl_done, m_axi_rready, m_axis_tvalid, m_axis_tlast});
    end
    r_force = 1'b0;
    apply_reset();
  endtask

  task automatic test_single_burst();
    run_xfer(64'h1000, 32'd4096, 400, -1);
    checks++;
    if (ar_log.size() != 1) begin errors++; $display("FAIL single_ar_count got %0d want 1", ar_log.size()); end
    if (ar_log.size() >= 1) begin
      checks++;
      if (ar_log[0].addr !== 64'h1000 || ar_log[0].len !== 8'd63) begin
        errors++;
        $display("FAIL single_ar got %h/%0d want 1000/63", ar_log[0].addr, ar_log[0].len);
      end
    end
    checks++;
    if (beat_data.size() != 64) begin errors++; $display("FAIL single_beats got %0d want 64", beat_data.size()); end
    checks++;
    if (data_bad(64'h1000) != 0) begin errors++; $display("FAIL single_data got %0d bad want 0", data_bad(64'h1000)); end
    checks++;
    if (tlast_count() != 1 || tlast_index() != 63) begin
      errors++; $display("FAIL single_tlast got cnt %0d idx %0d want 1/63", tlast_count(), tlast_index());
    end
    checks++;
    if (done_cyc.size() != 1) begin errors++; $display("FAIL single_done_count got %0d want 1", done_cyc.size()); end
    if (done_cyc.size() == 1 && beat_cyc.size() > 0) begin
      checks++;
      if (done_cyc[0] != beat_cyc[beat_cyc.size()-1] + 1) begin
        errors++; $display("FAIL single_done_cycle got %0d want %0d", done_cyc[0], beat_cyc[beat_cyc.size()-1] + 1);
      end
    end
    checks++;
    if (arvalid_cycles != 1) begin errors++; $display("FAIL single_arvalid_cycles got %0d want 1", arvalid_cycles); end
  endtask

  task automatic test_short_unaligned();
    run_xfer(64'h3040, 32'd100, 200, -1);
    checks++;
    if (ar_log.size() != 1) begin errors++; $display("FAIL short_ar_count got %0d want 1", ar_log.size()); end
    if (ar_log.size() >= 1) begin
      checks++;
      if (ar_log[0].addr !== 64'h3000 || ar_log[0].len !== 8'd1) begin
        errors++; $display("FAIL short_ar got %h/%0d want 3000/1", ar_log[0].addr, ar_log[0].len);
      end
    end
    checks++;
    if (beat_data.size() != 2 || data_bad(64'h3000) != 0 || tlast_index() != 1 || tlast_count() != 1) begin
      errors++;
      $display("FAIL short_stream got beats %0d bad %0d tlast %0d want 2/0/1",
               beat_data.size(), data_bad(64'h3000), tlast_index());
    end
  endtask

  task automatic test_multi_burst();
    run_xfer(64'h0, 32'd8256, 600, 10);
    checks++;
    if (ar_log.size() != 3) begin errors++; $display("FAIL multi_ar_count got %0d want 3", ar_log.size()); end
    if (ar_log.size() == 3) begin
      checks++;
      if (ar_log[0] !== '{addr: 64'h0, len: 8'd63} || ar_log[1] !== '{addr: 64'h1000, len: 8'd63}
          || ar_log[2] !== '{addr: 64'h2000, len: 8'd0}) begin
        errors++;
        $display("FAIL multi_ar got %h/%0d %h/%0d %h/%0d want 0/63 1000/63 2000/0",
                 ar_log[0].addr, ar_log[0].len, ar_log[1].addr, ar_log[1].len, ar_log[2].addr, ar_log[2].len);
      end
    end
    checks++;
    if (beat_data.size() != 129 || data_bad(64'h0) != 0) begin
      errors++; $display("FAIL multi_stream got beats %0d bad %0d want 129/0", beat_data.size(), data_bad(64'h0));
    end
    checks++;
    if (tlast_count() != 1 || tlast_index() != 128) begin
      errors++; $display("FAIL multi_tlast got cnt %0d idx %0d want 1/128", tlast_count(), tlast_index());
    end
    checks++;
    if (done_cyc.size() != 1) begin errors++; $display("FAIL multi_done_count got %0d want 1", done_cyc.size()); end
  endtask

  task automatic test_backpressure();
    tready_rand = 1'b1;
    run_xfer(64'h40000, 32'd8192, 1500, -1);
    tready_rand = 1'b0;
    checks++;
    if (rr_bad != 0) begin errors++; $display("FAIL bp_rready got %0d mismatching cycles want 0", rr_bad); end
    checks++;
    if (beat_data.size() != 128 || data_bad(64'h40000) != 0 || tlast_index() != 127) begin
      errors++;
      $display("FAIL bp_stream got beats %0d bad %0d tlast %0d want 128/0/127",
               beat_data.size(), data_bad(64'h40000), tlast_index());
    end
    checks++;
    if (done_cyc.size() != 1 || beat_cyc.size() == 0 || done_cyc[0] != beat_cyc[beat_cyc.size()-1] + 1) begin
      errors++; $display("FAIL bp_done got %0d pulses want 1 right after last beat", done_cyc.size());
    end
  endtask

  task automatic test_outstanding();
    reset_logs();
    r_enable = 1'b0; ar_ready_cfg = 1'b1; tready_cfg = 1'b1;
    ctrl_addr_offset = 64'h0;
    ctrl_xfer_size_in_bytes = 32'd163840;
    start_req = 1'b1;
    repeat (40) cycle();
    checks++;
    if (ar_log.size() != 16 || arvalid_cycles != 16) begin
      errors++; $display("FAIL outst_limit got ars %0d arvalid cycles %0d want 16/16", ar_log.size(), arvalid_cycles);
    end
    checks++;
    if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL outst_arvalid_low got %b want 0", m_axi_arvalid); end
    r_enable = 1'b1; r_release = 1;
    repeat (100) cycle();
    checks++;
    if (ar_log.size() != 17 || beat_data.size() != 64) begin
      errors++; $display("FAIL outst_release got ars %0d beats %0d want 17/64", ar_log.size(), beat_data.size());
    end
    if (ar_log.size() >= 17) begin
      checks++;
      if (ar_log[16] !== '{addr: 64'h10000, len: 8'd63}) begin
        errors++; $display("FAIL outst_next_ar got %h/%0d want 10000/63", ar_log[16].addr, ar_log[16].len);
      end
    end
    checks++;
    if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL outst_arvalid_relow got %b want 0", m_axi_arvalid); end
    r_release = -1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    reset_logs();
    ar_ready_cfg = 1'b0; r_force = 1'b1; tready_cfg = 1'b1;
    ctrl_addr_offset = 64'h0;
    ctrl_xfer_size_in_bytes = 32'd163840;
    start_req = 1'b1;
    repeat (3) cycle();
    checks++;
    if (m_axi_arvalid !== 1'b1 || m_axis_tvalid !== 1'b1) begin
      errors++; $display("FAIL midrst_busy got arvalid %b tvalid %b want 1/1", m_axi_arvalid, m_axis_tvalid);
    end
    areset_n = 1'b0;
    cycle();
    checks++;
    if ({m_axi_arvalid, m_axis_tvalid, ctrl_done} !== 3'b000) begin
      errors++; $display("FAIL midrst_low got %b want 000", {m_axi_arvalid, m_axis_tvalid, ctrl_done});
    end
    areset_n = 1'b1; r_force = 1'b0; ar_ready_cfg = 1'b1;
    ar_q.delete(); burst_beat = 0;
    cycle();
    run_xfer(64'h2000, 32'd100, 200, -1);
    checks++;
    if (ar_log.size() != 1 || beat_data.size() != 2 || data_bad(64'h2000) != 0 || done_cyc.size() != 1) begin
      errors++;
      $display("FAIL midrst_restart got ars %0d beats %0d bad %0d done %0d want 1/2/0/1",
               ar_log.size(), beat_data.size(), data_bad(64'h2000), done_cyc.size());
    end
  endtask

  task automatic test_zero_size();
    run_xfer(64'h5000, 32'd0, 20, -1);
    checks++;
    if (done_cyc.size() != 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", done_cyc.size()); end
    if (done_cyc.size() >= 1) begin
      checks++;
      if (done_cyc[0] != start_cyc + 2) begin
        errors++; $display("FAIL zero_done_cycle got %0d want %0d", done_cyc[0], start_cyc + 2);
      end
    end
    checks++;
    if (arvalid_cycles != 0 || beat_data.size() != 0) begin
      errors++; $display("FAIL zero_no_ar got arvalid %0d beats %0d want 0/0", arvalid_cycles, beat_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_short_unaligned();
    test_multi_burst();
    test_backpressure();
    test_zero_size();
    test_outstanding();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
